// File: rtl/mips_fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, fault cause codes, reset PC.
package mips_fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_DRAIN = 3'd2,
    S_VALID = 3'd3,
    S_FAULT = 3'd4
  } fetch_state_t;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_BUSERR   = 2'b10;
  localparam logic [1:0] FC_TIMEOUT  = 2'b11;

  localparam logic [31:0] MIPS_RESET_PC = 32'h00400000;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Counts outstanding-request cycles; saturates once the limit is reached.
module fetch_timeout_ctr #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] count;

  // Compare with >= so a count that runs past the limit (e.g. REQ -> DRAIN) still reads expired.
  assign expired = (count >= 8'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (reset || clr)
      count <= 8'd0;
    else if (en && !expired)
      count <= count + 8'd1;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch FSM: issues one word read per instruction, hands the word to decode, reports faults.
module instr_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = MIPS_RESET_PC,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        fetch_en,
  input  logic        flush,
  input  logic        consume,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        stall,
  output logic        fetch_fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_addr
);

  fetch_state_t state, state_n;
  logic         ld_addr, ld_instr, enter_fault, expired, busy;
  logic [1:0]   cause_n;
  logic [31:0]  faddr_n;

  assign busy  = (state == S_REQ) || (state == S_DRAIN);
  assign stall = fetch_en && (state != S_VALID);

  fetch_timeout_ctr #(.LIMIT(TIMEOUT)) u_tmo (
    .clk     (clk),
    .reset   (reset),
    .clr     (!busy),
    .en      (busy),
    .expired (expired)
  );

  always_comb begin
    state_n     = state;
    ld_addr     = 1'b0;
    ld_instr    = 1'b0;
    enter_fault = 1'b0;
    cause_n     = FC_NONE;
    faddr_n     = mem_addr;
    case (state)
      S_IDLE: begin
        if (fetch_en && !flush) begin
          ld_addr = 1'b1;
          if (pc[1:0] != 2'b00) begin
            state_n     = S_FAULT;
            enter_fault = 1'b1;
            cause_n     = FC_MISALIGN;
            faddr_n     = pc;
          end else begin
            state_n = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          // A redirect racing the ack wins: the word belongs to the old path.
          if (flush) begin
            state_n = S_IDLE;
          end else if (mem_err) begin
            state_n     = S_FAULT;
            enter_fault = 1'b1;
            cause_n     = FC_BUSERR;
          end else begin
            state_n  = S_VALID;
            ld_instr = 1'b1;
          end
        end else if (flush) begin
          state_n = S_DRAIN;
        end else if (expired) begin
          state_n     = S_FAULT;
          enter_fault = 1'b1;
          cause_n     = FC_TIMEOUT;
        end
      end
      S_DRAIN: begin
        if (mem_ack || expired) state_n = S_IDLE;
      end
      S_VALID, S_FAULT: begin
        if (consume || flush) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      mem_req     <= 1'b0;
      mem_addr    <= RESET_PC;
      instr       <= 32'h00000000;
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
      fault_cause <= FC_NONE;
      fault_addr  <= 32'h00000000;
    end else begin
      state       <= state_n;
      mem_req     <= (state_n == S_REQ) || (state_n == S_DRAIN);
      instr_valid <= (state_n == S_VALID);
      fetch_fault <= (state_n == S_FAULT);
      if (ld_addr)  mem_addr <= pc;
      if (ld_instr) instr    <= mem_rdata;
      if (enter_fault) begin
        fault_cause <= cause_n;
        fault_addr  <= faddr_n;
      end else if (state_n != S_FAULT) begin
        fault_cause <= FC_NONE;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with hand-computed expectations.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, fetch_en, flush, consume, mem_ack, mem_err;
  logic [31:0] pc, mem_rdata;
  logic        mem_req, instr_valid, stall, fetch_fault;
  logic [31:0] mem_addr, instr, fault_addr;
  logic [1:0]  fault_cause;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk(clk), .reset(reset), .pc(pc), .fetch_en(fetch_en), .flush(flush),
    .consume(consume), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .mem_err(mem_err), .instr(instr), .instr_valid(instr_valid),
    .stall(stall), .fetch_fault(fetch_fault), .fault_cause(fault_cause),
    .fault_addr(fault_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".mem_req"},     32'(mem_req),     32'd0);
    chk({tag, ".mem_addr"},    mem_addr,         32'h00400000);
    chk({tag, ".instr"},       instr,            32'h00000000);
    chk({tag, ".instr_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, ".fetch_fault"}, 32'(fetch_fault), 32'd0);
    chk({tag, ".fault_cause"}, 32'(fault_cause), 32'd0);
    chk({tag, ".fault_addr"},  fault_addr,       32'h00000000);
  endtask

  initial begin
    reset = 1'b1; fetch_en = 1'b0; flush = 1'b0; consume = 1'b0;
    mem_ack = 1'b0; mem_err = 1'b0; pc = 32'h0; mem_rdata = 32'h0;
    tick(); tick();
    reset = 1'b0;
    chk_reset_vals("rst");

    // Minimum-latency fetch
    pc = 32'h00400000; fetch_en = 1'b1;
    #1 chk("t1.stall_c0", 32'(stall), 32'd1);
    tick();
    chk("t1.req_c1",   32'(mem_req), 32'd1);
    chk("t1.addr_c1",  mem_addr,     32'h00400000);
    chk("t1.stall_c1", 32'(stall),   32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h2408000A;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    chk("t1.valid_c2", 32'(instr_valid), 32'd1);
    chk("t1.instr_c2", instr,            32'h2408000A);
    chk("t1.stall_c2", 32'(stall),       32'd0);
    chk("t1.req_c2",   32'(mem_req),     32'd0);
    consume = 1'b1; fetch_en = 1'b0;
    tick();
    consume = 1'b0;
    chk("t1.valid_done", 32'(instr_valid), 32'd0);

    // Misaligned PC
    pc = 32'h00400006; fetch_en = 1'b1;
    tick();
    chk("t2.fault", 32'(fetch_fault), 32'd1);
    chk("t2.cause", 32'(fault_cause), 32'd1);
    chk("t2.faddr", fault_addr,       32'h00400006);
    chk("t2.noreq", 32'(mem_req),     32'd0);
    fetch_en = 1'b0; consume = 1'b1;
    tick();
    consume = 1'b0;
    chk("t2.noreq2",  32'(mem_req),     32'd0);
    chk("t2.cleared", 32'(fetch_fault), 32'd0);
    chk("t2.cause0",  32'(fault_cause), 32'd0);

    // Bus error
    pc = 32'h00400010; fetch_en = 1'b1;
    tick();
    chk("t3.req", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_err = 1'b1; mem_rdata = 32'hFFFFFFFF;
    tick();
    mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = 32'h0;
    chk("t3.fault", 32'(fetch_fault), 32'd1);
    chk("t3.cause", 32'(fault_cause), 32'd2);
    chk("t3.faddr", fault_addr,       32'h00400010);
    chk("t3.novld", 32'(instr_valid), 32'd0);
    chk("t3.instr", instr,            32'h2408000A);
    fetch_en = 1'b0; consume = 1'b1;
    tick();
    consume = 1'b0;
    chk("t3.cleared", 32'(fetch_fault), 32'd0);
    chk("t3.noreq",   32'(mem_req),     32'd0);

    // Timeout after 16 REQ cycles
    pc = 32'h00400020; fetch_en = 1'b1;
    tick();
    for (int i = 1; i <= 15; i++) begin
      chk($sformatf("t4.req%0d", i), 32'(mem_req), 32'd1);
      tick();
    end
    chk("t4.req16",    32'(mem_req),     32'd1);
    chk("t4.nofault",  32'(fetch_fault), 32'd0);
    tick();
    chk("t4.fault",  32'(fetch_fault), 32'd1);
    chk("t4.cause",  32'(fault_cause), 32'd3);
    chk("t4.faddr",  fault_addr,       32'h00400020);
    chk("t4.reqoff", 32'(mem_req),     32'd0);
    fetch_en = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4.cleared", 32'(fetch_fault), 32'd0);

    // Flush in 2nd REQ cycle, late ack is drained and dropped
    pc = 32'h00400030; fetch_en = 1'b1;
    tick();
    tick();
    chk("t5.req2", 32'(mem_req), 32'd1);
    flush = 1'b1; fetch_en = 1'b0;
    tick();
    flush = 1'b0;
    chk("t5.drain_req1", 32'(mem_req),     32'd1);
    chk("t5.novld1",     32'(instr_valid), 32'd0);
    tick();
    chk("t5.drain_req2", 32'(mem_req),     32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    chk("t5.reqoff", 32'(mem_req),     32'd0);
    chk("t5.novld2", 32'(instr_valid), 32'd0);
    chk("t5.instr",  instr,            32'h2408000A);
    tick();
    chk("t5.novld3", 32'(instr_valid), 32'd0);
    chk("t5.nofault", 32'(fetch_fault), 32'd0);

    // Reset mid-REQ, late ack ignored
    pc = 32'h00400040; fetch_en = 1'b1;
    tick();
    chk("t6.req", 32'(mem_req), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0; fetch_en = 1'b0;
    chk_reset_vals("t6.rst");
    mem_ack = 1'b1; mem_rdata = 32'h11111111;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    chk_reset_vals("t6.late");
    tick();
    chk_reset_vals("t6.idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
